// File: rtl/lms_pkg.sv
// -----------------------------------------------------------------------------
// lms_pkg
// Shared definitions for the baud-rate LMS tap-update engine:
//   - FSM state encoding
//   - default fixed-point formats of regressor, equalizer output and taps
//   - centre-tap reset constant (1.0 in the tap format)
//   - widths of the complex products and their sums
// -----------------------------------------------------------------------------
package lms_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ERR  = 2'd1,
      ST_UPD  = 2'd2,
      ST_PUB  = 2'd3
   } lms_state_t;

   localparam int NUM_TAPS_DEF = 9;
   localparam int NBT_IN       = 8;    // regressor S(8,7)
   localparam int NBF_IN       = 7;
   localparam int NBT_EQ       = 12;   // equalizer output S(12,9)
   localparam int NBF_EQ       = 9;
   localparam int NBT_TAPS     = 28;   // taps S(28,25)
   localparam int NBF_TAPS     = 25;

   // Decision error carries one extra integer bit: S(13,9)
   localparam int ERR_W  = NBT_EQ + 1;
   // e * x products are S(21,16); the two-term sums are S(22,16)
   localparam int PROD_W = ERR_W + NBT_IN;
   localparam int SUM_W  = PROD_W + 1;

   // 1.0 in S(28,25)
   localparam logic signed [NBT_TAPS-1:0] CENTER_TAP =
      {{(NBT_TAPS-NBF_TAPS-1){1'b0}}, 1'b1, {NBF_TAPS{1'b0}}};

endpackage

// File: rtl/lms_grad_unit.sv
// -----------------------------------------------------------------------------
// lms_grad_unit
// Shared complex gradient datapath, one tap per cycle (purely combinational):
//   g_I = eI*xI + eQ*xQ,  g_Q = eQ*xI - eI*xQ   (e * conj(x))
//   w_next = sat(w - scale(g))            [default build]
//   w_next = sat(w - (w >>> LEAK_SHIFT) - scale(g))   [LMS_LEAKAGE_EN defined]
// scale() is an arithmetic shift by STEP_SHIFT-(NBF_TAPS-NBF_EQ-NBF_IN);
// a negative amount turns into a left shift. Results saturate to the tap range.
// Ports:
//   e_i/e_q           in  S(13,9)  decision error
//   x_i/x_q           in  S(8,7)   frozen regressor sample for this tap
//   w_i/w_q           in  S(28,25) current tap value
//   w_i_next/w_q_next out S(28,25) updated tap value
// Optional feature macro: LMS_LEAKAGE_EN
// -----------------------------------------------------------------------------
module lms_grad_unit
   import lms_pkg::*;
#(
   parameter int STEP_SHIFT = 11,
   parameter int LEAK_SHIFT = 16
)(
   input  logic signed [ERR_W-1:0]    e_i,
   input  logic signed [ERR_W-1:0]    e_q,
   input  logic signed [NBT_IN-1:0]   x_i,
   input  logic signed [NBT_IN-1:0]   x_q,
   input  logic signed [NBT_TAPS-1:0] w_i,
   input  logic signed [NBT_TAPS-1:0] w_q,
   output logic signed [NBT_TAPS-1:0] w_i_next,
   output logic signed [NBT_TAPS-1:0] w_q_next
);

   // Alignment of an S(22,16) gradient times 2^-STEP_SHIFT onto the tap LSB
   localparam int SHR   = STEP_SHIFT - (NBF_TAPS - NBF_EQ - NBF_IN);
   // Wide enough for any left shift plus the tap and a guard bit
   localparam int ACC_W = NBT_TAPS + SUM_W + 2;

   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-NBT_TAPS+1){1'b0}}, {(NBT_TAPS-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-NBT_TAPS+1){1'b1}}, {(NBT_TAPS-1){1'b0}}};

   logic signed [PROD_W-1:0] e_i_w, e_q_w, x_i_w, x_q_w;
   logic signed [PROD_W-1:0] p_ii, p_qq, p_qi, p_iq;
   logic signed [SUM_W-1:0]  g_i, g_q;
   logic signed [ACC_W-1:0]  g_i_ext, g_q_ext, s_i, s_q;
   logic signed [ACC_W-1:0]  w_i_ext, w_q_ext, l_i, l_q, r_i, r_q;

   // Operands widened up front so every product is computed at full width
   assign e_i_w = {{(PROD_W-ERR_W){e_i[ERR_W-1]}}, e_i};
   assign e_q_w = {{(PROD_W-ERR_W){e_q[ERR_W-1]}}, e_q};
   assign x_i_w = {{(PROD_W-NBT_IN){x_i[NBT_IN-1]}}, x_i};
   assign x_q_w = {{(PROD_W-NBT_IN){x_q[NBT_IN-1]}}, x_q};

   assign p_ii = e_i_w * x_i_w;
   assign p_qq = e_q_w * x_q_w;
   assign p_qi = e_q_w * x_i_w;
   assign p_iq = e_i_w * x_q_w;

   assign g_i = {p_ii[PROD_W-1], p_ii} + {p_qq[PROD_W-1], p_qq};
   assign g_q = {p_qi[PROD_W-1], p_qi} - {p_iq[PROD_W-1], p_iq};

   assign g_i_ext = {{(ACC_W-SUM_W){g_i[SUM_W-1]}}, g_i};
   assign g_q_ext = {{(ACC_W-SUM_W){g_q[SUM_W-1]}}, g_q};
   assign w_i_ext = {{(ACC_W-NBT_TAPS){w_i[NBT_TAPS-1]}}, w_i};
   assign w_q_ext = {{(ACC_W-NBT_TAPS){w_q[NBT_TAPS-1]}}, w_q};

   if (SHR >= 0) begin : g_shift_right
      assign s_i = g_i_ext >>> SHR;   // floor
      assign s_q = g_q_ext >>> SHR;
   end else begin : g_shift_left
      assign s_i = g_i_ext <<< (-SHR);
      assign s_q = g_q_ext <<< (-SHR);
   end

`ifdef LMS_LEAKAGE_EN
   assign l_i = w_i_ext >>> LEAK_SHIFT;
   assign l_q = w_q_ext >>> LEAK_SHIFT;
`else
   assign l_i = '0;
   assign l_q = '0;
   // Leakage is compiled out; LEAK_SHIFT is only range-qualified here.
   if (LEAK_SHIFT < 0) begin : g_leak_shift_negative
   end
`endif

   assign r_i = w_i_ext - l_i - s_i;
   assign r_q = w_q_ext - l_q - s_q;

   function automatic logic signed [NBT_TAPS-1:0] sat(input logic signed [ACC_W-1:0] v);
      if (v > SAT_MAX)
         return SAT_MAX[NBT_TAPS-1:0];
      else if (v < SAT_MIN)
         return SAT_MIN[NBT_TAPS-1:0];
      else
         return v[NBT_TAPS-1:0];
   endfunction

   assign w_i_next = sat(r_i);
   assign w_q_next = sat(r_q);

endmodule

// File: rtl/lms_tap_update.sv
// -----------------------------------------------------------------------------
// lms_tap_update
// Baud-rate LMS adaptation engine downstream of the fractionally spaced
// equalizer. Slices the equalizer output per rail, forms the decision error,
// updates all taps (one per cycle) against a frozen copy of the T/2 regressor
// and publishes the tap banks with a one-cycle load strobe.
// Ports:
//   clk, i_reset (async, active high), i_en_rx (low = synchronous clear)
//   i_ctrl, i_is_data_I/Q   regressor shift strobe and samples S(8,7)
//   i_eq_I/Q, i_sym_valid   equalizer output S(12,9) and baud strobe
//   i_en_adapt              enables the tap update for the captured symbol
//   o_taps_I/Q, o_en_taps   packed taps (tap j at [(j+1)*28-1 : j*28]), strobe
//   o_dec_I/Q, o_err_I/Q, o_dec_valid   decision sign, error S(13,9), valid
//   o_busy, o_overrun       update in progress, dropped i_sym_valid pulse
// Optional feature macro: LMS_LEAKAGE_EN (tap leakage inside lms_grad_unit)
// -----------------------------------------------------------------------------
module lms_tap_update
   import lms_pkg::*;
#(
   parameter int NUM_TAPS   = NUM_TAPS_DEF,
   parameter int SLICE_LVL  = 256,
   parameter int STEP_SHIFT = 11,
   parameter int LEAK_SHIFT = 16
)(
   input  logic                         clk,
   input  logic                         i_reset,
   input  logic                         i_en_rx,
   input  logic                         i_ctrl,
   input  logic [NBT_IN-1:0]            i_is_data_I,
   input  logic [NBT_IN-1:0]            i_is_data_Q,
   input  logic [NBT_EQ-1:0]            i_eq_I,
   input  logic [NBT_EQ-1:0]            i_eq_Q,
   input  logic                         i_sym_valid,
   input  logic                         i_en_adapt,
   output logic [NUM_TAPS*NBT_TAPS-1:0] o_taps_I,
   output logic [NUM_TAPS*NBT_TAPS-1:0] o_taps_Q,
   output logic                         o_en_taps,
   output logic                         o_dec_I,
   output logic                         o_dec_Q,
   output logic signed [ERR_W-1:0]      o_err_I,
   output logic signed [ERR_W-1:0]      o_err_Q,
   output logic                         o_dec_valid,
   output logic                         o_busy,
   output logic                         o_overrun
);

   localparam int KW     = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
   localparam int CENTER = NUM_TAPS / 2;
   localparam logic signed [ERR_W-1:0] SLICE = ERR_W'(SLICE_LVL);

   lms_state_t state_reg, state_next;

   logic [NUM_TAPS*NBT_IN-1:0] x_i_reg, x_q_reg;     // live regressor copy
   logic [NUM_TAPS*NBT_IN-1:0] xs_i_reg, xs_q_reg;   // frozen at capture
   logic [KW-1:0]              k_reg;
   logic                       adapt_reg;
   logic                       dec_i_reg, dec_q_reg, dec_valid_reg, en_taps_reg;
   logic signed [ERR_W-1:0]    err_i_reg, err_q_reg;

   logic signed [NBT_TAPS-1:0] w_i_reg   [NUM_TAPS];
   logic signed [NBT_TAPS-1:0] w_q_reg   [NUM_TAPS];
   logic signed [NBT_TAPS-1:0] pub_i_reg [NUM_TAPS];
   logic signed [NBT_TAPS-1:0] pub_q_reg [NUM_TAPS];

   logic signed [ERR_W-1:0]    y_i_ext, y_q_ext, err_i_next, err_q_next;
   logic signed [NBT_IN-1:0]   xk_i, xk_q;
   logic signed [NBT_TAPS-1:0] w_i_next, w_q_next;

   // Sign slicer: d = -SLICE for negative y, +SLICE otherwise; e = y - d.
   // Evaluated on the live input so the registered decision is visible during
   // the ERR cycle, which is also what the update phase consumes.
   assign y_i_ext    = {i_eq_I[NBT_EQ-1], i_eq_I};
   assign y_q_ext    = {i_eq_Q[NBT_EQ-1], i_eq_Q};
   assign err_i_next = i_eq_I[NBT_EQ-1] ? (y_i_ext + SLICE) : (y_i_ext - SLICE);
   assign err_q_next = i_eq_Q[NBT_EQ-1] ? (y_q_ext + SLICE) : (y_q_ext - SLICE);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (i_sym_valid) state_next = ST_ERR;
         ST_ERR:  state_next = adapt_reg ? ST_UPD : ST_IDLE;
         ST_UPD:  if (k_reg == KW'(NUM_TAPS-1)) state_next = ST_PUB;
         ST_PUB:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
      if (!i_en_rx)
         state_next = ST_IDLE;
   end

   // ---------------- Regressor copy (tap 0 = newest sample) ----------------
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         x_i_reg <= '0;
         x_q_reg <= '0;
      end else if (!i_en_rx) begin
         x_i_reg <= '0;
         x_q_reg <= '0;
      end else if (i_ctrl) begin
         x_i_reg <= {x_i_reg[(NUM_TAPS-1)*NBT_IN-1:0], i_is_data_I};
         x_q_reg <= {x_q_reg[(NUM_TAPS-1)*NBT_IN-1:0], i_is_data_Q};
      end
   end

   // ---------------- Shared gradient datapath ----------------
   assign xk_i = xs_i_reg[k_reg*NBT_IN +: NBT_IN];
   assign xk_q = xs_q_reg[k_reg*NBT_IN +: NBT_IN];

   lms_grad_unit #(
      .STEP_SHIFT (STEP_SHIFT),
      .LEAK_SHIFT (LEAK_SHIFT)
   ) u_grad (
      .e_i      (err_i_reg),
      .e_q      (err_q_reg),
      .x_i      (xk_i),
      .x_q      (xk_q),
      .w_i      (w_i_reg[k_reg]),
      .w_q      (w_q_reg[k_reg]),
      .w_i_next (w_i_next),
      .w_q_next (w_q_next)
   );

   // ---------------- Capture, update and publish ----------------
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         xs_i_reg      <= '0;
         xs_q_reg      <= '0;
         k_reg         <= '0;
         adapt_reg     <= 1'b0;
         dec_i_reg     <= 1'b0;
         dec_q_reg     <= 1'b0;
         err_i_reg     <= '0;
         err_q_reg     <= '0;
         dec_valid_reg <= 1'b0;
         en_taps_reg   <= 1'b0;
         for (int j = 0; j < NUM_TAPS; j++) begin
            w_i_reg[j]   <= (j == CENTER) ? CENTER_TAP : '0;
            w_q_reg[j]   <= '0;
            pub_i_reg[j] <= (j == CENTER) ? CENTER_TAP : '0;
            pub_q_reg[j] <= '0;
         end
      end else if (!i_en_rx) begin
         xs_i_reg      <= '0;
         xs_q_reg      <= '0;
         k_reg         <= '0;
         adapt_reg     <= 1'b0;
         dec_i_reg     <= 1'b0;
         dec_q_reg     <= 1'b0;
         err_i_reg     <= '0;
         err_q_reg     <= '0;
         dec_valid_reg <= 1'b0;
         en_taps_reg   <= 1'b0;
         for (int j = 0; j < NUM_TAPS; j++) begin
            w_i_reg[j]   <= (j == CENTER) ? CENTER_TAP : '0;
            w_q_reg[j]   <= '0;
            pub_i_reg[j] <= (j == CENTER) ? CENTER_TAP : '0;
            pub_q_reg[j] <= '0;
         end
      end else begin
         dec_valid_reg <= 1'b0;
         en_taps_reg   <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (i_sym_valid) begin
                  xs_i_reg      <= x_i_reg;
                  xs_q_reg      <= x_q_reg;
                  dec_i_reg     <= i_eq_I[NBT_EQ-1];
                  dec_q_reg     <= i_eq_Q[NBT_EQ-1];
                  err_i_reg     <= err_i_next;
                  err_q_reg     <= err_q_next;
                  dec_valid_reg <= 1'b1;
                  adapt_reg     <= i_en_adapt;
                  k_reg         <= '0;
               end
            end
            ST_UPD: begin
               w_i_reg[k_reg] <= w_i_next;
               w_q_reg[k_reg] <= w_q_next;
               k_reg          <= k_reg + 1'b1;
            end
            ST_PUB: begin
               for (int j = 0; j < NUM_TAPS; j++) begin
                  pub_i_reg[j] <= w_i_reg[j];
                  pub_q_reg[j] <= w_q_reg[j];
               end
               en_taps_reg <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ---------------- Outputs ----------------
   for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_pack
      assign o_taps_I[gi*NBT_TAPS +: NBT_TAPS] = pub_i_reg[gi];
      assign o_taps_Q[gi*NBT_TAPS +: NBT_TAPS] = pub_q_reg[gi];
   end

   assign o_en_taps   = en_taps_reg;
   assign o_dec_I     = dec_i_reg;
   assign o_dec_Q     = dec_q_reg;
   assign o_err_I     = err_i_reg;
   assign o_err_Q     = err_q_reg;
   assign o_dec_valid = dec_valid_reg;
   assign o_busy      = (state_reg != ST_IDLE);
   // A baud strobe that lands while an update is running is dropped
   assign o_overrun   = i_sym_valid && i_en_rx && (state_reg != ST_IDLE);

endmodule

// File: tb/tb_lms_tap_update.sv
module tb_lms_tap_update;
   import lms_pkg::*;

   localparam int NT = 9;
   localparam int TW = NT * NBT_TAPS;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              i_reset, i_en_rx, i_ctrl, i_sym_valid, i_en_adapt;
   logic [NBT_IN-1:0] i_is_data_I, i_is_data_Q;
   logic [NBT_EQ-1:0] i_eq_I, i_eq_Q;

   logic [TW-1:0]            o_taps_I, o_taps_Q, s_taps_I, s_taps_Q;
   logic                     o_en_taps, o_dec_I, o_dec_Q, o_dec_valid, o_busy, o_overrun;
   logic                     s_en_taps, s_dec_I, s_dec_Q, s_dec_valid, s_busy, s_overrun;
   logic signed [ERR_W-1:0]  o_err_I, o_err_Q, s_err_I, s_err_Q;

   lms_tap_update dut (
      .clk(clk), .i_reset(i_reset), .i_en_rx(i_en_rx), .i_ctrl(i_ctrl),
      .i_is_data_I(i_is_data_I), .i_is_data_Q(i_is_data_Q),
      .i_eq_I(i_eq_I), .i_eq_Q(i_eq_Q), .i_sym_valid(i_sym_valid), .i_en_adapt(i_en_adapt),
      .o_taps_I(o_taps_I), .o_taps_Q(o_taps_Q), .o_en_taps(o_en_taps),
      .o_dec_I(o_dec_I), .o_dec_Q(o_dec_Q), .o_err_I(o_err_I), .o_err_Q(o_err_Q),
      .o_dec_valid(o_dec_valid), .o_busy(o_busy), .o_overrun(o_overrun)
   );

   // Same stimulus, unit step size: used for the saturation corner
   lms_tap_update #(.STEP_SHIFT(0)) dut_sat (
      .clk(clk), .i_reset(i_reset), .i_en_rx(i_en_rx), .i_ctrl(i_ctrl),
      .i_is_data_I(i_is_data_I), .i_is_data_Q(i_is_data_Q),
      .i_eq_I(i_eq_I), .i_eq_Q(i_eq_Q), .i_sym_valid(i_sym_valid), .i_en_adapt(i_en_adapt),
      .o_taps_I(s_taps_I), .o_taps_Q(s_taps_Q), .o_en_taps(s_en_taps),
      .o_dec_I(s_dec_I), .o_dec_Q(s_dec_Q), .o_err_I(s_err_I), .o_err_Q(s_err_Q),
      .o_dec_valid(s_dec_valid), .o_busy(s_busy), .o_overrun(s_overrun)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   int en_cnt = 0;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_vec(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   longint wi_m[NT], wq_m[NT], xi_m[NT], xq_m[NT];

   task automatic model_reset();
      for (int j = 0; j < NT; j++) begin
         wi_m[j] = 0; wq_m[j] = 0; xi_m[j] = 0; xq_m[j] = 0;
      end
      wi_m[NT/2] = longint'(1) <<< 25;
   endtask

   function automatic longint sat28(input longint v);
      longint hi, lo;
      hi = (longint'(1) <<< 27) - 1;
      lo = -(longint'(1) <<< 27);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // mu = 2^-11 on S(22,16) gradients landing in S(28,25) taps -> >>> 2
   task automatic model_update(input longint ei, input longint eq);
      longint gi, gq;
      for (int k = 0; k < NT; k++) begin
         gi = ei * xi_m[k] + eq * xq_m[k];
         gq = eq * xi_m[k] - ei * xq_m[k];
         wi_m[k] = sat28(wi_m[k] - (gi >>> 2));
         wq_m[k] = sat28(wq_m[k] - (gq >>> 2));
      end
   endtask

   function automatic logic [TW-1:0] pack_i();
      logic [TW-1:0] v;
      v = '0;
      for (int j = 0; j < NT; j++) v[j*NBT_TAPS +: NBT_TAPS] = wi_m[j][NBT_TAPS-1:0];
      return v;
   endfunction

   function automatic logic [TW-1:0] pack_q();
      logic [TW-1:0] v;
      v = '0;
      for (int j = 0; j < NT; j++) v[j*NBT_TAPS +: NBT_TAPS] = wq_m[j][NBT_TAPS-1:0];
      return v;
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      int t;
      logic dec_i, dec_q;
      int err_i, err_q;
   } dec_exp_t;

   typedef struct {
      int t;
      logic [TW-1:0] taps_i, taps_q;
   } tap_exp_t;

   dec_exp_t dec_sb[$];
   tap_exp_t tap_sb[$];
   dec_exp_t de_m;
   tap_exp_t te_m;

   always @(negedge clk) begin
      if (o_dec_valid === 1'b1) begin
         if (dec_sb.size() == 0) begin
            total++; bad++;
            $display("FAIL dec_valid_spurious: got pulse at cycle %0d expected none", cyc);
         end else begin
            de_m = dec_sb.pop_front();
            $display("dec  t=%0d dec=(%0d,%0d) err=(%0d,%0d)", de_m.t, o_dec_I, o_dec_Q, o_err_I, o_err_Q);
            chk("dec_cycle", cyc, de_m.t + 1);
            chk("dec_I", o_dec_I, de_m.dec_i);
            chk("dec_Q", o_dec_Q, de_m.dec_q);
            chk("err_I", o_err_I, de_m.err_i);
            chk("err_Q", o_err_Q, de_m.err_q);
         end
      end
      if (o_en_taps === 1'b1) begin
         en_cnt++;
         if (tap_sb.size() == 0) begin
            total++; bad++;
            $display("FAIL en_taps_spurious: got pulse at cycle %0d expected none", cyc);
         end else begin
            te_m = tap_sb.pop_front();
            $display("taps t=%0d tap0=(%0d,%0d) tap4_I=%0d", te_m.t,
                     $signed(o_taps_I[NBT_TAPS-1:0]), $signed(o_taps_Q[NBT_TAPS-1:0]),
                     $signed(o_taps_I[4*NBT_TAPS +: NBT_TAPS]));
            chk("en_taps_cycle", cyc, te_m.t + NT + 3);
            chk_vec("taps_I", o_taps_I, te_m.taps_i);
            chk_vec("taps_Q", o_taps_Q, te_m.taps_q);
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic load_x(input int xi, input int xq);
      @(posedge clk); #1;
      i_ctrl = 1'b1; i_is_data_I = xi[NBT_IN-1:0]; i_is_data_Q = xq[NBT_IN-1:0];
      for (int j = NT-1; j > 0; j--) begin
         xi_m[j] = xi_m[j-1]; xq_m[j] = xq_m[j-1];
      end
      xi_m[0] = xi; xq_m[0] = xq;
      @(posedge clk); #1;
      i_ctrl = 1'b0;
   endtask

   // Drives one baud strobe; adapt drops again right after capture.
   task automatic send_sym(input int yi, input int yq, input bit adapt,
                           input bit di, input bit dqv, input int ei, input int eq,
                           input bit push_taps, output int t);
      dec_exp_t d;
      tap_exp_t tp;
      @(posedge clk); #1;
      i_sym_valid = 1'b1; i_en_adapt = adapt;
      i_eq_I = yi[NBT_EQ-1:0]; i_eq_Q = yq[NBT_EQ-1:0];
      t = cyc;
      d.t = t; d.dec_i = di; d.dec_q = dqv; d.err_i = ei; d.err_q = eq;
      dec_sb.push_back(d);
      if (adapt && push_taps) begin
         model_update(ei, eq);
         tp.t = t; tp.taps_i = pack_i(); tp.taps_q = pack_q();
         tap_sb.push_back(tp);
      end
      @(posedge clk); #1;
      i_sym_valid = 1'b0; i_en_adapt = 1'b0;
   endtask

   typedef struct {
      bit load; int xi, xq;
      int yi, yq; bit adapt;
      bit dec_i, dec_q; int err_i, err_q;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected test end");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, e0;
      vecs[0] = '{0,    0,    0,   256, -256, 1, 0, 1,     0,    0};
      vecs[1] = '{1,   64,    0,   320,  256, 1, 0, 0,    64,    0};
      vecs[2] = '{0,    0,    0,  -300,  100, 1, 1, 0,   -44, -156};
      vecs[3] = '{1,   -5,   17, -2048, 2047, 0, 1, 0, -1792, 1791};
      vecs[4] = '{1,  100, -100,     0,   -1, 1, 0, 1,  -256,  255};
      vecs[5] = '{1, -128,  127,    10,  -20, 1, 0, 1,  -246,  236};

      i_reset = 1'b1; i_en_rx = 1'b1; i_ctrl = 1'b0; i_sym_valid = 1'b0; i_en_adapt = 1'b0;
      i_is_data_I = '0; i_is_data_Q = '0; i_eq_I = '0; i_eq_Q = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 i_reset = 1'b0;

      // reset state
      @(negedge clk);
      chk_vec("reset_taps_I", o_taps_I, pack_i());
      chk_vec("reset_taps_Q", o_taps_Q, pack_q());
      chk("reset_tap4_I", $signed(o_taps_I[4*NBT_TAPS +: NBT_TAPS]), 64'sh2000000);
      chk("reset_en_taps", o_en_taps, 0);
      chk("reset_busy", o_busy, 0);
      chk("reset_overrun", o_overrun, 0);
      chk("reset_dec_valid", o_dec_valid, 0);

      // table-driven symbols
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].load) load_x(vecs[i].xi, vecs[i].xq);
         send_sym(vecs[i].yi, vecs[i].yq, vecs[i].adapt, vecs[i].dec_i, vecs[i].dec_q,
                  vecs[i].err_i, vecs[i].err_q, 1'b1, t);
         repeat (14) @(posedge clk);
         if (i == 1) begin
            @(negedge clk);
            chk("single_tap0_I", $signed(o_taps_I[NBT_TAPS-1:0]), -1024);
            chk("single_tap0_Q", $signed(o_taps_Q[NBT_TAPS-1:0]), 0);
            chk("single_tap4_I", $signed(o_taps_I[4*NBT_TAPS +: NBT_TAPS]), 64'sh2000000);
         end
      end

      // overrun: second strobe at t+5 is dropped, one o_en_taps at t+12
      e0 = en_cnt;
      send_sym(200, -50, 1'b1, 1'b0, 1'b1, -56, 206, 1'b1, t);
      repeat (4) @(posedge clk);
      #1 i_sym_valid = 1'b1; i_eq_I = 12'd700; i_eq_Q = 12'd5;
      @(negedge clk);
      chk("overrun_cycle", cyc, t + 5);
      chk("overrun_pulse", o_overrun, 1);
      chk("overrun_busy", o_busy, 1);
      @(posedge clk); #1 i_sym_valid = 1'b0;
      @(negedge clk);
      chk("overrun_clear", o_overrun, 0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("busy_last_cycle", o_busy, 1);
      @(negedge clk);
      chk("busy_dropped", o_busy, 0);
      repeat (4) @(posedge clk);
      chk("overrun_one_en_taps", en_cnt - e0, 1);

      // reset in the middle of an update
      send_sym(500, -600, 1'b1, 1'b0, 1'b1, 244, -344, 1'b0, t);
      repeat (4) @(posedge clk);
      #1 i_reset = 1'b1;
      model_reset();
      e0 = en_cnt;
      #1;
      chk_vec("midreset_taps_I", o_taps_I, pack_i());
      chk_vec("midreset_taps_Q", o_taps_Q, pack_q());
      chk("midreset_busy", o_busy, 0);
      @(posedge clk); #1 i_reset = 1'b0;
      repeat (14) @(posedge clk);
      chk("midreset_no_en_taps", en_cnt - e0, 0);

      // saturation on the unit-step instance: two updates of tap 0
      load_x(-128, 0);
      send_sym(2047, 0, 1'b1, 1'b0, 1'b0, 1791, -256, 1'b1, t);
      repeat (14) @(posedge clk);
      @(negedge clk);
      chk("sat_first_tap0_I", $signed(s_taps_I[NBT_TAPS-1:0]), 117374976);
      send_sym(2047, 0, 1'b1, 1'b0, 1'b0, 1791, -256, 1'b1, t);
      repeat (14) @(posedge clk);
      @(negedge clk);
      chk("sat_tap0_I", $signed(s_taps_I[NBT_TAPS-1:0]), 64'sh7FFFFFF);
      chk("sat_tap0_Q", $signed(s_taps_Q[NBT_TAPS-1:0]), -33554432);
      chk("sat_tap4_I", $signed(s_taps_I[4*NBT_TAPS +: NBT_TAPS]), 64'sh2000000);

      // i_en_rx low clears back to the reset state
      @(posedge clk); #1 i_en_rx = 1'b0;
      @(posedge clk); #1 i_en_rx = 1'b1;
      model_reset();
      @(negedge clk);
      chk_vec("enrx_clear_taps_I", o_taps_I, pack_i());
      chk_vec("enrx_clear_taps_Q", o_taps_Q, pack_q());

      repeat (3) @(posedge clk);
      chk("dec_sb_drained", dec_sb.size(), 0);
      chk("tap_sb_drained", tap_sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
